// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the IF/MEM memory-port arbiter.
// FSM encoding, default bus timeout and word-address helpers.
package mem_arb_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_I_BUSY = 3'd1;
  localparam logic [2:0] ST_I_DONE = 3'd2;
  localparam logic [2:0] ST_D_BUSY = 3'd3;
  localparam logic [2:0] ST_D_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    I_BUSY = ST_I_BUSY,
    I_DONE = ST_I_DONE,
    D_BUSY = ST_D_BUSY,
    D_DONE = ST_D_DONE
  } arb_state_e;

  localparam int unsigned TIMEOUT_DEF = 255;

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_addr(
    input logic [31:0] a
  );
    return a & ADDR_MASK;
  endfunction

endpackage

// File: rtl/mem_arb_ibuf.sv
// mem_arb_ibuf: one-entry fetch buffer {valid, word address, data}.
// Ports: clk/rst (sync, active-low), fill_*, inv_* (store snoop),
//   lookup_addr_i, hit_o/data_o (combinational lookup result).
module mem_arb_ibuf
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_i,
  input  logic [31:0] fill_addr_i,
  input  logic [31:0] fill_data_i,
  input  logic        inv_i,
  input  logic [31:0] inv_addr_i,
  input  logic [31:0] lookup_addr_i,
  output logic        hit_o,
  output logic [31:0] data_o
);

  logic        valid_q, valid_d;
  logic [31:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = word_addr(fill_addr_i);
      data_d  = fill_data_i;
    end
    // a store to the buffered word makes the copy stale
    if (inv_i && (word_addr(inv_addr_i) == tag_q)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q &&
                  (word_addr(lookup_addr_i) == tag_q);
  assign data_o = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between IF and MEM.
// Ports: rom_* (fetch), ram_*/data_* (load/store), mem_* (bus), bus_err.
// Optional fetch buffer: define MEM_ARB_IBUF_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_cs,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        rom_stall,
  input  logic        ram_cs,
  input  logic        data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        ram_stall,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  // wait count seen in the last BUSY cycle before abort
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  arb_state_e  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        ibuf_hit;

`ifdef MEM_ARB_IBUF_EN
  logic        ibuf_match;
  logic [31:0] ibuf_data;
  logic        ibuf_fill;
  logic        ibuf_inv;

  // timed-out fetches return a fake zero word: never cache it
  assign ibuf_fill = (state_q == I_DONE) && !bus_err_q;
  assign ibuf_inv  = (state_q == IDLE) && ram_cs && data_wen;

  mem_arb_ibuf u_ibuf (
    .clk           (clk),
    .rst           (rst),
    .fill_i        (ibuf_fill),
    .fill_addr_i   (mem_addr_q),
    .fill_data_i   (inst_data_q),
    .inv_i         (ibuf_inv),
    .inv_addr_i    (data_addr),
    .lookup_addr_i (inst_addr),
    .hit_o         (ibuf_match),
    .data_o        (ibuf_data)
  );

  // data keeps priority: a pending MEM access blocks the hit
  assign ibuf_hit  = ibuf_match && (state_q == IDLE) &&
                     rom_cs && !ram_cs;
  assign inst_data = ibuf_hit ? ibuf_data : inst_data_q;
`else
  assign ibuf_hit  = 1'b0;
  assign inst_data = inst_data_q;
`endif

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    mem_req_d    = mem_req_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_data_d  = inst_data_q;
    data_rdata_d = data_rdata_q;
    bus_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ram_cs) begin
          state_d     = D_BUSY;
          wait_d      = '0;
          mem_req_d   = 1'b1;
          mem_wen_d   = data_wen;
          mem_addr_d  = word_addr(data_addr);
          mem_wdata_d = data_wdata;
        end else if (rom_cs && !ibuf_hit) begin
          state_d    = I_BUSY;
          wait_d     = '0;
          mem_req_d  = 1'b1;
          mem_wen_d  = 1'b0;
          mem_addr_d = word_addr(inst_addr);
        end
      end

      I_BUSY, D_BUSY: begin
        wait_d = wait_q + 8'd1;
        if (mem_ack) begin
          state_d   = (state_q == I_BUSY) ? I_DONE : D_DONE;
          mem_req_d = 1'b0;
          mem_wen_d = 1'b0;
          if (state_q == I_BUSY) inst_data_d = mem_rdata;
          else                   data_rdata_d = mem_rdata;
        end else if (wait_q == WAIT_LAST) begin
          // abort so the pipeline can never deadlock
          state_d   = (state_q == I_BUSY) ? I_DONE : D_DONE;
          mem_req_d = 1'b0;
          mem_wen_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == I_BUSY) inst_data_d = '0;
          else                   data_rdata_d = '0;
        end
      end

      I_DONE, D_DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_data_q  <= '0;
      data_rdata_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      mem_req_q    <= mem_req_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_data_q  <= inst_data_d;
      data_rdata_q <= data_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign rom_stall  = rom_cs && (state_q != I_DONE) && !ibuf_hit;
  assign ram_stall  = ram_cs && (state_q != D_DONE);
  assign data_rdata = data_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed per-cycle vector table for mem_arbiter
// plus hand-written reset and wait-latency sequences.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rom_cs;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        rom_stall;
  logic        ram_cs;
  logic        data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        ram_stall;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  int checks;
  int failures;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_cs     (rom_cs),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .rom_stall  (rom_stall),
    .ram_cs     (ram_cs),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .ram_stall  (ram_stall),
    .mem_req    (mem_req),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        rom;
    logic [31:0] ia;
    logic        ram;
    logic        wen;
    logic [31:0] da;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rd;
    logic        e_rs;
    logic        e_ms;
    logic        e_req;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_err;
    logic        ci;
    logic [31:0] ei;
    logic        cd;
    logic [31:0] ed;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input string n,
    input bit [31:0] r, rom, ia, ram, wen, da, wd, ack, rd,
    input bit [31:0] ers, ems, ereq, ewen, eaddr, ewd, eerr,
    input bit [31:0] ci, ei, cd, ed
  );
    vec_t v;
    v.name = n;   v.rst = r[0];   v.rom = rom[0]; v.ia = ia;
    v.ram = ram[0]; v.wen = wen[0]; v.da = da;    v.wd = wd;
    v.ack = ack[0]; v.rd = rd;
    v.e_rs = ers[0]; v.e_ms = ems[0]; v.e_req = ereq[0];
    v.e_wen = ewen[0]; v.e_addr = eaddr; v.e_wd = ewd;
    v.e_err = eerr[0];
    v.ci = ci[0]; v.ei = ei; v.cd = cd[0]; v.ed = ed;
    return v;
  endfunction

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, want %b", n, act, exp);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rom_cs = 0; inst_addr = '0; ram_cs = 0; data_wen = 0;
    data_addr = '0; data_wdata = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // reset values
    @(negedge clk);
    chk1("rst:mem_req", mem_req, 1'b0);
    chk1("rst:mem_wen", mem_wen, 1'b0);
    chk1("rst:bus_err", bus_err, 1'b0);
    chk1("rst:rom_stall", rom_stall, 1'b0);
    chk1("rst:ram_stall", ram_stall, 1'b0);
    chk32("rst:mem_addr", mem_addr, 32'h0);
    chk32("rst:mem_wdata", mem_wdata, 32'h0);
    chk32("rst:inst_data", inst_data, 32'h0);
    chk32("rst:data_rdata", data_rdata, 32'h0);
    @(posedge clk);
    #1;

    // fields: name rst rom ia ram wen da wd ack rd |
    //         rs ms req wen addr wd err | ci ei cd ed
    // zero-wait fetch
    vq.push_back(mk("f0",1,1,'h40,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("f1",1,1,'h40,0,0,0,0,1,'h24080005, 1,0,1,0,'h40,0,0, 0,0,0,0));
    vq.push_back(mk("f2",1,1,'h40,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,'h24080005,0,0));
    vq.push_back(mk("f3",1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    // collision, ack in second BUSY cycle
    vq.push_back(mk("c0",1,1,'h44,1,0,'h100,0,0,0, 1,1,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("c1",1,1,'h44,1,0,'h100,0,0,0, 1,1,1,0,'h100,0,0, 0,0,0,0));
    vq.push_back(mk("c2",1,1,'h44,1,0,'h100,0,1,'h11112222, 1,1,1,0,'h100,0,0, 0,0,0,0));
    vq.push_back(mk("c3",1,1,'h44,1,0,'h100,0,0,0, 1,0,0,0,0,0,0, 0,0,1,'h11112222));
    vq.push_back(mk("c4",1,1,'h44,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("c5",1,1,'h44,0,0,0,0,0,0, 1,0,1,0,'h44,0,0, 0,0,0,0));
    vq.push_back(mk("c6",1,1,'h44,0,0,0,0,1,'h33334444, 1,0,1,0,'h44,0,0, 0,0,0,0));
    vq.push_back(mk("c7",1,1,'h44,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,'h33334444,0,0));
    vq.push_back(mk("c8",1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    // store with unaligned address
    vq.push_back(mk("s0",1,0,0,1,1,'h203,'hDEADBEEF,0,0, 0,1,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("s1",1,0,0,1,1,'h203,'hDEADBEEF,1,0, 0,1,1,1,'h200,'hDEADBEEF,0, 0,0,0,0));
    vq.push_back(mk("s2",1,0,0,1,1,'h203,'hDEADBEEF,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("s3",1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    // timeout after 4 BUSY cycles; late ack in IDLE ignored
    vq.push_back(mk("t0",1,0,0,1,0,'h300,0,0,0, 0,1,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("t1",1,0,0,1,0,'h300,0,0,0, 0,1,1,0,'h300,0,0, 0,0,0,0));
    vq.push_back(mk("t2",1,0,0,1,0,'h300,0,0,0, 0,1,1,0,'h300,0,0, 0,0,0,0));
    vq.push_back(mk("t3",1,0,0,1,0,'h300,0,0,0, 0,1,1,0,'h300,0,0, 0,0,0,0));
    vq.push_back(mk("t4",1,0,0,1,0,'h300,0,0,0, 0,1,1,0,'h300,0,0, 0,0,0,0));
    vq.push_back(mk("t5",1,0,0,1,0,'h300,0,0,0, 0,0,0,0,0,0,1, 0,0,1,0));
    vq.push_back(mk("t6",1,0,0,0,0,0,0,1,'h55555555, 0,0,0,0,0,0,0, 0,0,1,0));
    vq.push_back(mk("t7",1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,1,0));
    // ack exactly in the last allowed BUSY cycle wins over abort
    vq.push_back(mk("b0",1,0,0,1,0,'h304,0,0,0, 0,1,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("b1",1,0,0,1,0,'h304,0,0,0, 0,1,1,0,'h304,0,0, 0,0,0,0));
    vq.push_back(mk("b2",1,0,0,1,0,'h304,0,0,0, 0,1,1,0,'h304,0,0, 0,0,0,0));
    vq.push_back(mk("b3",1,0,0,1,0,'h304,0,0,0, 0,1,1,0,'h304,0,0, 0,0,0,0));
    vq.push_back(mk("b4",1,0,0,1,0,'h304,0,1,'hCAFEF00D, 0,1,1,0,'h304,0,0, 0,0,0,0));
    vq.push_back(mk("b5",1,0,0,1,0,'h304,0,0,0, 0,0,0,0,0,0,0, 0,0,1,'hCAFEF00D));
    vq.push_back(mk("b6",1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    // fetch flushed during BUSY still completes on the bus
    vq.push_back(mk("x0",1,1,'h60,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("x1",1,0,0,0,0,0,0,0,0, 0,0,1,0,'h60,0,0, 0,0,0,0));
    vq.push_back(mk("x2",1,0,0,0,0,0,0,1,'h77, 0,0,1,0,'h60,0,0, 0,0,0,0));
    vq.push_back(mk("x3",1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("x4",1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
    // reset in the second BUSY cycle abandons the fetch
    vq.push_back(mk("r0",1,1,'h50,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("r1",1,1,'h50,0,0,0,0,0,0, 1,0,1,0,'h50,0,0, 0,0,0,0));
    vq.push_back(mk("r2",0,1,'h50,0,0,0,0,0,0, 1,0,1,0,'h50,0,0, 0,0,0,0));
    vq.push_back(mk("r3",0,1,'h50,0,0,0,0,0,0, 1,0,0,0,0,0,0, 1,0,0,0));
    vq.push_back(mk("r4",0,0,0,1,0,0,0,0,0, 0,1,0,0,0,0,0, 0,0,1,0));
    vq.push_back(mk("r5",1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
`ifdef MEM_ARB_IBUF_EN
    // fetch 0x80, load while IF holds, hit, store, refetch misses
    vq.push_back(mk("i0",1,1,'h80,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("i1",1,1,'h80,0,0,0,0,1,'h80808080, 1,0,1,0,'h80,0,0, 0,0,0,0));
    vq.push_back(mk("i2",1,1,'h80,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,'h80808080,0,0));
    vq.push_back(mk("i3",1,1,'h80,1,0,'h400,0,0,0, 1,1,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("i4",1,1,'h80,1,0,'h400,0,1,1, 1,1,1,0,'h400,0,0, 0,0,0,0));
    vq.push_back(mk("i5",1,1,'h80,1,0,'h400,0,0,0, 1,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("i6",1,1,'h80,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,'h80808080,0,0));
    vq.push_back(mk("i7",1,1,'h80,1,1,'h80,0,0,0, 1,1,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("i8",1,1,'h80,1,1,'h80,0,1,0, 1,1,1,1,'h80,0,0, 0,0,0,0));
    vq.push_back(mk("i9",1,1,'h80,1,1,'h80,0,0,0, 1,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("i10",1,1,'h80,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk("i11",1,1,'h80,0,0,0,0,1,'h12345678, 1,0,1,0,'h80,0,0, 0,0,0,0));
    vq.push_back(mk("i12",1,1,'h80,0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,'h12345678,0,0));
    vq.push_back(mk("i13",1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
`endif

    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      rst = v.rst;      rom_cs = v.rom;    inst_addr = v.ia;
      ram_cs = v.ram;   data_wen = v.wen;  data_addr = v.da;
      data_wdata = v.wd; mem_ack = v.ack;  mem_rdata = v.rd;
      @(negedge clk);
      chk1({v.name, ":rom_stall"}, rom_stall, v.e_rs);
      chk1({v.name, ":ram_stall"}, ram_stall, v.e_ms);
      chk1({v.name, ":mem_req"}, mem_req, v.e_req);
      chk1({v.name, ":bus_err"}, bus_err, v.e_err);
      if (v.e_req) begin
        chk1({v.name, ":mem_wen"}, mem_wen, v.e_wen);
        chk32({v.name, ":mem_addr"}, mem_addr, v.e_addr);
        if (v.e_wen)
          chk32({v.name, ":mem_wdata"}, mem_wdata, v.e_wd);
      end
      if (v.ci) chk32({v.name, ":inst_data"}, inst_data, v.ei);
      if (v.cd) chk32({v.name, ":data_rdata"}, data_rdata, v.ed);
      @(posedge clk);
      #1;
    end

    // fetch with 3 wait cycles: stall must last 2 + 3 cycles
    begin
      int n_req;
      int stall_cyc;
      bit done;
      n_req = 0;
      stall_cyc = 0;
      done = 0;
      idle_inputs();
      rom_cs = 1;
      inst_addr = 32'h70;
      for (int k = 0; k < 20 && !done; k++) begin
        mem_ack = mem_req && (n_req == 3);
        mem_rdata = 32'hABCD_0123;
        @(negedge clk);
        if (rom_stall) stall_cyc++;
        else done = 1;
        if (mem_req) n_req++;
        @(posedge clk);
        #1;
      end
      checks++;
      if (!done) begin
        failures++;
        $display("FAIL lat:bound rom_stall still high after 20 cycles");
      end
      chk32("lat:stall_cycles", 32'(stall_cyc), 32'd5);
      chk32("lat:req_cycles", 32'(n_req), 32'd4);
      idle_inputs();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
